// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields and an immediate into an
// instruction word, flags out-of-range immediates, and buffers results in a FIFO.
module inst_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    input  logic [2:0]       immType,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst_out,
    output logic             err_out,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [31:0]      mem_inst_q [DEPTH];
    logic [31:0]      mem_inst_d [DEPTH];
    logic             mem_err_q  [DEPTH];
    logic             mem_err_d  [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [31:0]      last_inst_q, last_inst_d;
    logic             last_err_q, last_err_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic        push;
    logic        pop;
    logic        imm_err;
    logic [31:0] packed_word;
    logic [31:0] entry_word;
    logic        i_range_ok;
    logic        b_range_ok;
    logic        j_range_ok;

    // An immediate fits a field when every bit above the field's sign bit matches it.
    assign i_range_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_range_ok = (&imm[31:12]) | ~(|imm[31:12]);
    assign j_range_ok = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        imm_err     = 1'b0;
        packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
        case (immType)
            IMM_I: begin
                packed_word = {imm[11:0], rs1, funct3, rd, opcode};
                imm_err     = ~i_range_ok;
            end
            IMM_S: begin
                packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                imm_err     = ~i_range_ok;
            end
            IMM_B: begin
                packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                imm_err     = ~b_range_ok | imm[0];
            end
            IMM_U: begin
                packed_word = {imm[31:12], rd, opcode};
                imm_err     = |imm[11:0];
            end
            IMM_J: begin
                packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                imm_err     = ~j_range_ok | imm[0];
            end
            default: begin
            end
        endcase
        entry_word = imm_err ? NOP_WORD : packed_word;
    end

    assign in_ready  = (count_q < FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The head mux falls back to the last popped entry so outputs hold while empty.
    assign inst_out  = out_valid ? mem_inst_q[rd_ptr_q] : last_inst_q;
    assign err_out   = out_valid ? mem_err_q[rd_ptr_q]  : last_err_q;
    assign err_count = err_count_q;

    always_comb begin
        mem_inst_d  = mem_inst_q;
        mem_err_d   = mem_err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_inst_d = last_inst_q;
        last_err_d  = last_err_q;
        err_count_d = err_count_q;

        if (push) begin
            mem_inst_d[wr_ptr_q] = entry_word;
            mem_err_d[wr_ptr_q]  = imm_err;
            wr_ptr_d             = wr_ptr_q + AW'(1);
            if (imm_err && (err_count_q != '1)) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            last_inst_d = mem_inst_q[rd_ptr_q];
            last_err_d  = mem_err_q[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_inst_q  <= '{default: '0};
            mem_err_q   <= '{default: 1'b0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_inst_q <= '0;
            last_err_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            mem_inst_q  <= mem_inst_d;
            mem_err_q   <= mem_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_inst_q <= last_inst_d;
            last_err_q  <= last_err_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: fixed vectors, backpressure, streaming,
// randomized traffic against a decode-side reference model, and async reset.
module tb_inst_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;
    localparam logic [2:0] IMM_R = 3'd7;

    typedef struct {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  itype;
    } req_t;

    typedef struct {
        req_t        req;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       opcode = '0;
    logic [4:0]       rd = '0;
    logic [4:0]       rs1 = '0;
    logic [4:0]       rs2 = '0;
    logic [2:0]       funct3 = '0;
    logic [6:0]       funct7 = '0;
    logic [31:0]      imm = '0;
    logic [2:0]       immType = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      inst_out;
    logic             err_out;
    logic [CNT_W-1:0] err_count;

    int checks = 0;
    int failures = 0;
    req_t model_q[$];
    int model_errs = 0;

    inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .immType(immType), .out_valid(out_valid),
        .out_ready(out_ready), .inst_out(inst_out), .err_out(err_out),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Immediate generator view of a packed word, used to prove the round trip.
    function automatic logic [31:0] imm_gen(input logic [31:0] w, input logic [2:0] t);
        case (t)
            IMM_I:   return {{20{w[31]}}, w[31:20]};
            IMM_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            IMM_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            IMM_U:   return {w[31:12], 12'h000};
            IMM_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_err(input req_t r);
        int v;
        v = int'(r.imm);
        case (r.itype)
            IMM_I, IMM_S: return (v < -2048) || (v > 2047);
            IMM_B:        return (v < -4096) || (v > 4095) || r.imm[0];
            IMM_J:        return (v < -1048576) || (v > 1048575) || r.imm[0];
            IMM_U:        return (r.imm % 4096) != 0;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic word_ok(input req_t r, input logic [31:0] w);
        logic ok;
        ok = (w[6:0] == r.opcode);
        if (r.itype inside {IMM_I, IMM_U, IMM_J} || r.itype > IMM_J) ok &= (w[11:7] == r.rd);
        if (r.itype inside {IMM_I, IMM_S, IMM_B} || r.itype > IMM_J) begin
            ok &= (w[19:15] == r.rs1) && (w[14:12] == r.funct3);
        end
        if (r.itype inside {IMM_S, IMM_B} || r.itype > IMM_J) ok &= (w[24:20] == r.rs2);
        if (r.itype > IMM_J) ok &= (w[31:25] == r.funct7);
        else                 ok &= (imm_gen(w, r.itype) == r.imm);
        return ok;
    endfunction

    task automatic check_head(input req_t r);
        logic exp_err;
        logic ok;
        exp_err = model_err(r);
        ok = (err_out === exp_err) && (exp_err ? (inst_out === 32'h13) : word_ok(r, inst_out));
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL head actual inst=0x%08h err=%0b required err=%0b imm=0x%08h type=%0d",
                     inst_out, err_out, exp_err, r.imm, r.itype);
        end
    endtask

    task automatic drive(input req_t r);
        opcode  = r.opcode;
        rd      = r.rd;
        rs1     = r.rs1;
        rs2     = r.rs2;
        funct3  = r.funct3;
        funct7  = r.funct7;
        imm     = r.imm;
        immType = r.itype;
    endtask

    // One cycle, entered and left at a falling edge; compares against the model queue.
    task automatic apply_stimulus(input req_t r, input logic v, input logic ordy, output logic acc);
        logic pop;
        drive(r);
        in_valid  = v;
        out_ready = ordy;
        check_output("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
        check_output("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) check_head(model_q[0]);
        acc = v && (model_q.size() < DEPTH);
        pop = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (pop) void'(model_q.pop_front());
        if (acc) begin
            model_q.push_back(r);
            if (model_err(r) && model_errs < 65535) model_errs++;
        end
        @(negedge clk);
    endtask

    function automatic req_t rand_req(input logic legal_only);
        req_t r;
        int sel;
        r.opcode = 7'($urandom);
        r.rd     = 5'($urandom);
        r.rs1    = 5'($urandom);
        r.rs2    = 5'($urandom);
        r.funct3 = 3'($urandom);
        r.funct7 = 7'($urandom);
        r.itype  = 3'($urandom_range(0, 7));
        sel = int'($urandom_range(0, 9));
        case (r.itype)
            IMM_I, IMM_S: r.imm = (sel == 0) ? -32'sd2048 : (sel == 1) ? 32'd2047
                                : 32'(int'($urandom_range(0, 4095)) - 2048);
            IMM_B: r.imm = (sel == 0) ? -32'sd4096 : (sel == 1) ? 32'd4094
                         : 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
            IMM_J: r.imm = (sel == 0) ? -32'sd1048576 : (sel == 1) ? 32'd1048574
                         : 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
            IMM_U: r.imm = {20'($urandom), 12'h000};
            default: r.imm = $urandom;
        endcase
        if (!legal_only && $urandom_range(0, 5) == 0) r.imm = $urandom;
        return r;
    endfunction

    function automatic vec_t mk(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] im, input logic [2:0] t,
                                input logic [31:0] ei, input logic ee);
        vec_t v;
        v.req = '{opcode: op, rd: d, rs1: s1, rs2: s2, funct3: f3, funct7: f7, imm: im, itype: t};
        v.exp_inst = ei;
        v.exp_err  = ee;
        return v;
    endfunction

    initial begin
        vec_t tbl[13];
        req_t r;
        logic acc;
        int tbl_errs;
        int accepts;
        int seen;

        tbl[0]  = mk(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, IMM_I, 32'hFFF1_0093, 1'b0);
        tbl[1]  = mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001, IMM_B, 32'h0000_0013, 1'b1);
        tbl[2]  = mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, IMM_U, 32'h1234_52B7, 1'b0);
        tbl[3]  = mk(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, IMM_R, 32'h4031_00B3, 1'b0);
        tbl[4]  = mk(7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'h0000_0008, IMM_S, 32'h0051_2423, 1'b0);
        tbl[5]  = mk(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h0000_0800, IMM_I, 32'h0000_0013, 1'b1);
        tbl[6]  = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, IMM_J, 32'hFFDF_F0EF, 1'b0);
        tbl[7]  = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_FFF8, IMM_B, 32'hFE20_8CE3, 1'b0);
        tbl[8]  = mk(7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0800, IMM_U, 32'h0000_0013, 1'b1);
        tbl[9]  = mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0003, IMM_J, 32'h0000_0013, 1'b1);
        tbl[10] = mk(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_1000, IMM_B, 32'h0000_0013, 1'b1);
        tbl[11] = mk(7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, IMM_S, 32'h8000_0023, 1'b0);
        tbl[12] = mk(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_07FF, IMM_I, 32'h7FF0_0013, 1'b0);

        $display("[TB] reset checks");
        @(negedge clk);
        @(negedge clk);
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_inst_out", inst_out, 32'd0);
        check_output("rst_err_out", 32'(err_out), 32'd0);
        check_output("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] vector table");
        tbl_errs = 0;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].req);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            tbl_errs += int'(tbl[i].exp_err);
            check_output($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            check_output($sformatf("vec%0d_inst", i), inst_out, tbl[i].exp_inst);
            check_output($sformatf("vec%0d_err", i), 32'(err_out), 32'(tbl[i].exp_err));
            check_output($sformatf("vec%0d_errcnt", i), 32'(err_count), 32'(tbl_errs));
            @(posedge clk);
            @(negedge clk);
            check_output($sformatf("vec%0d_empty", i), 32'(out_valid), 32'd0);
            check_output($sformatf("vec%0d_hold", i), inst_out, tbl[i].exp_inst);
        end
        model_errs = tbl_errs;

        $display("[TB] backpressure");
        accepts = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            r = rand_req(1'b1);
            r.itype = IMM_I;
            r.imm   = 32'(i);
            apply_stimulus(r, 1'b1, 1'b0, acc);
            accepts += int'(acc);
        end
        check_output("bp_accepts", 32'(accepts), 32'(DEPTH));
        check_output("bp_in_ready_full", 32'(in_ready), 32'd0);
        for (int i = 0; i < DEPTH + 1; i++) apply_stimulus(r, 1'b0, 1'b1, acc);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(rand_req(1'b0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
        end
        for (int i = 0; i < DEPTH + 1; i++) apply_stimulus(r, 1'b0, 1'b1, acc);

        $display("[TB] streaming");
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            seen += int'(out_valid === 1'b1);
            apply_stimulus(rand_req(1'b1), 1'b1, 1'b1, acc);
        end
        check_output("stream_words", 32'(seen), 32'd99);
        for (int i = 0; i < 2; i++) apply_stimulus(r, 1'b0, 1'b1, acc);
        check_output("errcnt_total", 32'(err_count), 32'(model_errs));

        $display("[TB] async reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            r = rand_req(1'b1);
            if (i == 1) begin
                r.itype = IMM_I;
                r.imm   = 32'd4096;
            end
            apply_stimulus(r, 1'b1, 1'b0, acc);
        end
        in_valid = 1'b0;
        check_output("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_valid", 32'(out_valid), 32'd0);
        check_output("mid_rst_errcnt", 32'(err_count), 32'd0);
        check_output("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_output("mid_rst_inst", inst_out, 32'd0);
        model_q.delete();
        model_errs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        r = rand_req(1'b1);
        apply_stimulus(r, 1'b1, 1'b0, acc);
        check_output("post_rst_valid", 32'(out_valid), 32'd1);
        apply_stimulus(r, 1'b0, 1'b1, acc);
        apply_stimulus(r, 1'b0, 1'b1, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Inverse of the immediate generator. Takes decoded instruction fields plus a 32-bit immediate and its format, range-checks the immediate, and packs a legal RV32I instruction word. Results are buffered in a small FIFO with valid/ready handshakes on both sides. It feeds the test-program loader and the self-check path, where the immediate generator's output must equal the original imm for every error-free word.

Parameters:
DEPTH, 4, output FIFO entries (power of 2, >=2)
CNT_W, 16, width of saturating error counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept (FIFO not full)
opcode  input  7  inst[6:0]
rd  input  5  destination register
rs1  input  5  source 1
rs2  input  5  source 2
funct3  input  3  funct3
funct7  input  7  funct7 (R-format only)
imm  input  32  immediate, two's complement
immType  input  3  IMM_I/IMM_S/IMM_B/IMM_U/IMM_J per params.vh; other = R-format
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
inst_out  output  32  packed instruction at FIFO head
err_out  output  1  head entry failed range/alignment check
err_count  output  CNT_W  saturating count of accepted erroneous requests

Behaviour:
- Reset (async assert, sync release): FIFO empty, out_valid=0, inst_out=0, err_out=0, err_count=0, in_ready=1.
- Accept when in_valid && in_ready. in_ready = (count < DEPTH), with no combinational dependence on out_ready (no pass-through when full).
- Pack, combinational at accept, written into FIFO tail:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
  - other: {funct7, rs2, rs1, funct3, rd, opcode}; imm ignored; never an error.
- Error rules:
  - I, S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
- Erroneous entry: inst_out stored as 32'h0000_0013 (NOP), err bit=1. Field inputs are still not validated.
- Latency: an entry accepted in cycle N is visible at the head (out_valid=1) in cycle N+1 if the FIFO was empty. Order is strictly FIFO.
- Pop when out_valid && out_ready. Head outputs hold stable while out_valid && !out_ready.
- Simultaneous push and pop: allowed whenever in_ready=1, and count is unchanged. When full, only pop occurs; in_ready rises the cycle after the pop.
- Pointers wrap modulo DEPTH. count width is log2(DEPTH)+1.
- When empty: out_valid=0, and inst_out/err_out hold their last value (0 after reset).
- err_count increments on accept of an erroneous entry and saturates at all-ones.
- rst_n asserted mid-stream: all entries are discarded immediately and err_count clears.

Test Plan:
- I-type: opcode=0x13, rd=1, rs1=2, funct3=0, imm=-1, immType=IMM_I -> next cycle inst_out=0xFFF10093, err_out=0; immGen(inst_out, IMM_I)=0xFFFFFFFF.
- Range/alignment: IMM_B with imm=0x1001 -> err_out=1, inst_out=0x00000013, err_count=1. IMM_U with imm=0x12345000, rd=5, opcode=0x37 -> 0x123452B7, err=0.
- Round-trip sweep: random fields, all five types, legal imm including boundaries (I: -2048/2047, B: -4096/4094, J: -1048576/1048574) -> immGen(inst_out, type)==imm and err_out=0 for every entry.
- Backpressure: out_ready=0, push DEPTH+2 requests -> in_ready=0 after DEPTH accepts. Release out_ready -> all DEPTH words are popped in order, with no loss or duplication.
- Streaming: in_valid=out_ready=1 for 100 cycles -> one word per cycle at steady state, count constant, pointers wrap correctly.
- Async reset mid-stream with 3 entries queued -> out_valid=0 and err_count=0 without a clock edge; the first post-reset request appears after 1 cycle.
